// File: rtl/dlsc_clkgen_prog_rx.sv
// ---------------------------------------------------------------------------
// dlsc_clkgen_prog_rx
//
// Receiver for the DCM_CLKGEN serial M/D reprogramming port. A programming
// master frames commands with prog_en and shifts them in LSB first on
// prog_data:
//   LOADD : 10 bits {D-1[7:0], 0, 1}
//   LOADM : 10 bits {M-1[7:0], 1, 1}
//   GO    : single bit 0
// LOADD/LOADM update pending registers; GO starts a DONE_DELAY countdown
// after which the pending values are committed to out_mult/out_div.
//
// Ports:
//   clk        : sole clock (doubles as PROGCLK)
//   rst        : synchronous, active-high reset
//   prog_en    : command frame enable
//   prog_data  : serial command data, sampled while prog_en=1
//   prog_done  : high when idle/committed, low while a GO is in progress
//   out_mult   : committed M-1
//   out_div    : committed D-1
//   out_update : one-cycle pulse coincident with newly committed values
//   err        : one-cycle protocol-error pulse (only with the check macro)
//
// Parameters:
//   MULT_RESET : reset value of out_mult and pending multiply
//   DIV_RESET  : reset value of out_div and pending divide
//   DONE_DELAY : cycles from GO acceptance to commit, legal range 1-255
//
// Optional feature macro: DLSC_CLKGEN_PROG_RX_CHECK_EN
//   Defined   : err reports aborts, prog_en held into END, prog_en during
//               BUSY and invalid-multiply commits.
//   Undefined : err is tied low and the checker is not built.
// ---------------------------------------------------------------------------
module dlsc_clkgen_prog_rx #(
  parameter logic [7:0] MULT_RESET = 8'd3,
  parameter logic [7:0] DIV_RESET  = 8'd0,
  parameter int         DONE_DELAY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_en,
  input  logic       prog_data,
  output logic       prog_done,
  output logic [7:0] out_mult,
  output logic [7:0] out_div,
  output logic       out_update,
  output logic       err
);

  localparam logic [7:0] DELAY_INIT = 8'(DONE_DELAY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_DATA,
    ST_END,
    ST_BUSY
  } state_t;

  state_t     state_q, state_d;
  logic       sel_mult_q, sel_mult_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;      // 7 most recent data bits; 8th arrives live
  logic [7:0] pend_mult_q, pend_mult_d;
  logic [7:0] pend_div_q, pend_div_d;
  logic [7:0] delay_q, delay_d;
  logic       done_q, done_d;
  logic [7:0] mult_q, mult_d;
  logic [7:0] div_q, div_d;
  logic       update_q, update_d;

  logic [7:0] data_in;
  logic       commit;

  // Full byte as it stands once the current bit is included.
  assign data_in = {prog_data, shift_q};
  // Countdown is loaded with DONE_DELAY and commits on its last BUSY cycle,
  // so the committed values become visible DONE_DELAY+1 cycles after GO.
  assign commit  = (state_q == ST_BUSY) && (delay_q == 8'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sel_mult_d  = sel_mult_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pend_mult_d = pend_mult_q;
    pend_div_d  = pend_div_q;
    delay_d     = delay_q;
    done_d      = done_q;
    mult_d      = mult_q;
    div_d       = div_q;
    update_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (prog_en) begin
          if (prog_data) begin
            state_d = ST_SEL;
          end else begin
            state_d = ST_BUSY;
            delay_d = DELAY_INIT;
            done_d  = 1'b0;
          end
        end
      end
      ST_SEL: begin
        if (!prog_en) begin
          state_d = ST_IDLE;
        end else begin
          sel_mult_d = prog_data;
          bit_cnt_d  = 3'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!prog_en) begin
          state_d = ST_IDLE;
        end else begin
          shift_d   = data_in[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (sel_mult_q) pend_mult_d = data_in;
            else            pend_div_d  = data_in;
            state_d = ST_END;
          end
        end
      end
      ST_END: begin
        if (!prog_en) state_d = ST_IDLE;
      end
      ST_BUSY: begin
        // prog_en is deliberately ignored here.
        if (commit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // M=1 is not a legal multiplier: keep the old outputs, but still
          // raise prog_done so the master does not hang.
          if (pend_mult_q != 8'd0) begin
            mult_d   = pend_mult_q;
            div_d    = pend_div_q;
            update_d = 1'b1;
          end
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_mult_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      pend_mult_q <= MULT_RESET;
      pend_div_q  <= DIV_RESET;
      delay_q     <= 8'd0;
      done_q      <= 1'b1;
      mult_q      <= MULT_RESET;
      div_q       <= DIV_RESET;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_mult_q  <= sel_mult_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pend_mult_q <= pend_mult_d;
      pend_div_q  <= pend_div_d;
      delay_q     <= delay_d;
      done_q      <= done_d;
      mult_q      <= mult_d;
      div_q       <= div_d;
      update_q    <= update_d;
    end
  end

  assign prog_done  = done_q;
  assign out_mult   = mult_q;
  assign out_div    = div_q;
  assign out_update = update_q;

`ifdef DLSC_CLKGEN_PROG_RX_CHECK_EN
  logic err_q, err_d;
  logic end_first_q, end_first_d;    // high only on the first END cycle
  logic busy_seen_q, busy_seen_d;    // prog_en already flagged this BUSY period

  always_comb begin
    err_d       = 1'b0;
    end_first_d = (state_q == ST_DATA) && (state_d == ST_END);
    busy_seen_d = (state_q == ST_BUSY) ? (busy_seen_q | prog_en) : 1'b0;

    if ((state_q == ST_SEL || state_q == ST_DATA) && !prog_en) err_d = 1'b1;
    if (state_q == ST_END && end_first_q && prog_en)            err_d = 1'b1;
    if (state_q == ST_BUSY && prog_en && !busy_seen_q)          err_d = 1'b1;
    if (commit && pend_mult_q == 8'd0)                          err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      end_first_q <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      end_first_q <= end_first_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dlsc_clkgen_prog_rx.sv
// ---------------------------------------------------------------------------
// Testbench for dlsc_clkgen_prog_rx.
// Commands are generated at protocol level (load / aborted load / GO); the
// reference model tracks pending and committed values and derives expected
// per-cycle outputs from the documented latencies. Directed table vectors
// and hand-written corner sequences are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_dlsc_clkgen_prog_rx;

  localparam int         DD     = 8;
  localparam logic [7:0] M_RST  = 8'd3;
  localparam logic [7:0] D_RST  = 8'd0;
`ifdef DLSC_CLKGEN_PROG_RX_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_en = 1'b0;
  logic       prog_data = 1'b0;
  logic       prog_done;
  logic [7:0] out_mult;
  logic [7:0] out_div;
  logic       out_update;
  logic       err;

  dlsc_clkgen_prog_rx #(
    .MULT_RESET (M_RST),
    .DIV_RESET  (D_RST),
    .DONE_DELAY (DD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_en    (prog_en),
    .prog_data  (prog_data),
    .prog_done  (prog_done),
    .out_mult   (out_mult),
    .out_div    (out_div),
    .out_update (out_update),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  // ---------------- reference model ----------------
  bit         model_valid = 1'b0;
  int         cur;
  int         go_cycle = -1;      // cycle in which GO was driven, -1 = none
  logic [7:0] pm, pd;             // pending M-1 / D-1
  logic [7:0] em, ed;             // expected committed outputs
  logic [7:0] gm, gd;             // values snapshotted when GO was issued
  bit         gvalid;
  bit         err_at[int];        // cycles in which err must be high

  function automatic void add_err(input int c);
    if (CHECK_EN) err_at[c] = 1'b1;
  endfunction

  function automatic void model_reset();
    pm = M_RST; pd = D_RST; em = M_RST; ed = D_RST;
    go_cycle = -1;
    err_at.delete();
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit commit, busy, exp_upd, exp_err;
    commit  = (go_cycle >= 0) && (cur == go_cycle + 1 + DD);
    busy    = (go_cycle >= 0) && (cur > go_cycle) && (cur <= go_cycle + DD);
    exp_upd = commit && gvalid;
    if (exp_upd) begin
      em = gm;
      ed = gd;
    end
    exp_err = err_at.exists(cur) || (commit && !gvalid && CHECK_EN);
    check("prog_done",  {7'd0, prog_done},  {7'd0, !busy});
    check("out_mult",   out_mult,           em);
    check("out_div",    out_div,            ed);
    check("out_update", {7'd0, out_update}, {7'd0, exp_upd});
    check("err",        {7'd0, err},        {7'd0, exp_err});
    if (commit) go_cycle = -1;
  endtask

  // One cycle: check the current cycle's outputs, then apply inputs that the
  // DUT samples at the next rising edge.
  task automatic drive(input bit r, input bit en, input bit d);
    @(negedge clk);
    cur = cyc;
    if (model_valid) check_outputs();
    rst = r;
    prog_en = en;
    prog_data = d;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    model_reset();
    model_valid = 1'b1;
  endtask

  // abort_at: -1 complete, 0 abort in SEL, k=1..7 abort after k data bits.
  // hold: extra cycles prog_en stays high in END.
  task automatic send_load(input bit is_mult, input logic [7:0] v,
                           input int abort_at, input int hold);
    drive(1'b0, 1'b1, 1'b1);
    if (abort_at == 0) begin
      drive(1'b0, 1'b0, 1'b0);
      add_err(cur + 1);
      return;
    end
    drive(1'b0, 1'b1, is_mult);
    for (int i = 0; i < 8; i++) begin
      if (abort_at >= 1 && i == abort_at) begin
        drive(1'b0, 1'b0, 1'b0);
        add_err(cur + 1);
        return;
      end
      drive(1'b0, 1'b1, v[i]);
    end
    if (is_mult) pm = v;
    else         pd = v;
    for (int h = 0; h < hold; h++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (h == 0) add_err(cur + 1);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // GO plus the DD busy cycles; optionally toggles prog_en while busy.
  task automatic send_go(input bit pulses);
    bit first;
    bit en;
    drive(1'b0, 1'b1, 1'b0);
    go_cycle = cur;
    gm = pm;
    gd = pd;
    gvalid = (pm != 8'd0);
    first = 1'b1;
    for (int i = 0; i < DD; i++) begin
      en = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(1'b0, en, 1'($urandom_range(0, 1)));
      if (en && first) begin
        add_err(cur + 1);
        first = 1'b0;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] exp_mult;
    logic [7:0] exp_div;
    logic       exp_upd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int go_t;
    vecs[0] = '{d: 8'h04, m: 8'h09, exp_mult: 8'h09, exp_div: 8'h04, exp_upd: 1'b1};
    vecs[1] = '{d: 8'h10, m: 8'h00, exp_mult: 8'h09, exp_div: 8'h04, exp_upd: 1'b0};
    vecs[2] = '{d: 8'hff, m: 8'hff, exp_mult: 8'hff, exp_div: 8'hff, exp_upd: 1'b1};
    vecs[3] = '{d: 8'h00, m: 8'h01, exp_mult: 8'h01, exp_div: 8'h00, exp_upd: 1'b1};

    drive(1'b1, 1'b0, 1'b0);
    do_reset();
    drive(1'b0, 1'b0, 1'b0);
    check("rst_done", {7'd0, prog_done}, 8'd1);
    check("rst_mult", out_mult, 8'd3);
    check("rst_div",  out_div,  8'd0);
    check("rst_err",  {7'd0, err}, 8'd0);

    for (int i = 0; i < 4; i++) begin
      send_load(1'b0, vecs[i].d, -1, 0);
      send_load(1'b1, vecs[i].m, -1, 0);
      drive(1'b0, 1'b1, 1'b0);        // GO, then hand over to the model
      go_t = cur;
      go_cycle = cur; gm = pm; gd = pd; gvalid = (pm != 8'd0);
      drive(1'b0, 1'b0, 1'b0);
      check("tbl_done_low", {7'd0, prog_done}, 8'd0);
      for (int k = 1; k < DD; k++) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);        // cycle go_t + 1 + DD
      check("tbl_commit_cycle", cur[7:0], 8'(go_t + 1 + DD));
      check("tbl_mult", out_mult, vecs[i].exp_mult);
      check("tbl_div",  out_div,  vecs[i].exp_div);
      check("tbl_upd",  {7'd0, out_update}, {7'd0, vecs[i].exp_upd});
      check("tbl_done", {7'd0, prog_done}, 8'd1);
    end

    // Aborted LOADD must leave the previous pending divide in place.
    send_load(1'b0, 8'h22, -1, 0);
    send_load(1'b0, 8'h55, 5, 0);
    send_go(1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("abort_div", out_div, 8'h22);
    check("abort_upd", {7'd0, out_update}, 8'd1);

    // prog_en pulses while busy do not move the completion cycle.
    send_load(1'b1, 8'h05, -1, 1);
    send_go(1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("pulse_mult", out_mult, 8'h05);
    check("pulse_done", {7'd0, prog_done}, 8'd1);

    // Reset mid-BUSY: no commit, then a GO commits the reset values.
    send_load(1'b1, 8'h07, -1, 0);
    drive(1'b0, 1'b1, 1'b0);
    go_cycle = cur; gm = pm; gd = pd; gvalid = (pm != 8'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < DD + 2; k++) drive(1'b0, 1'b0, 1'b0);
    send_go(1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("rst_busy_mult", out_mult, M_RST);
    check("rst_busy_div",  out_div,  D_RST);
    check("rst_busy_upd",  {7'd0, out_update}, 8'd1);

    // Randomized command stream.
    for (int n = 0; n < 80; n++) begin
      int r;
      int hold;
      logic [7:0] v;
      r = $urandom_range(0, 9);
      v = 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      case (r)
        0, 1, 2: send_load(1'b0, v, -1, hold);
        3, 4, 5: send_load(1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : v, -1, hold);
        6:       send_load(1'($urandom_range(0, 1)), v, $urandom_range(0, 7), 0);
        7, 8:    send_go(1'($urandom_range(0, 1)));
        default: drive(1'b0, 1'b0, 1'b0);
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) drive(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < DD + 2; k++) drive(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dlsc_clkgen_prog_rx.md
# dlsc_clkgen_prog_rx

Receiver for the DCM_CLKGEN serial M/D reprogramming port (PROGEN/PROGDATA/PROGDONE). Decodes LOADD, LOADM and GO commands from a programming master and presents the committed multiply/divide values to downstream logic. Used as a synthesizable responder for soft-clock-divider designs, and as a bench model to close the loop on DCM programming controllers.

## Interface
- `MULT_RESET`, default 3: reset value of `out_mult` and pending multiply (M-1).
- `DIV_RESET`, default 0: reset value of `out_div` and pending divide (D-1).
- `DONE_DELAY`, default 8: cycles from GO acceptance to commit/`prog_done` reassertion; legal range 1-255.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock; also the programming clock (PROGCLK).
- `rst` in 1: reset, synchronous, active-high.
- `prog_en` in 1: program enable; frames each command.
- `prog_data` in 1: serial command data, sampled when `prog_en`=1.
- `prog_done` out 1: high when idle or committed; low while a GO is in progress.
- `out_mult` out 8: committed M-1.
- `out_div` out 8: committed D-1.
- `out_update` out 1: one-cycle pulse on the commit cycle.
- `err` out 1: one-cycle protocol-error pulse; see Configuration.

## Operation
- Command formats, bits sent LSB first, one bit per cycle with `prog_en`=1:
  - LOADD: 10 bits, {D-1[7:0], 0, 1}.
  - LOADM: 10 bits, {M-1[7:0], 1, 1}.
  - GO: single bit 0.
- States: IDLE, SEL, DATA, END, BUSY.
- IDLE, `prog_en`=1:
  - `prog_data`=0 (GO): go to BUSY, load `DONE_DELAY` into the countdown.
  - `prog_data`=1: go to SEL.
- SEL: the sampled bit selects the target register (0 = divide, 1 = multiply). Clear the bit counter and go to DATA.
- DATA: shift 8 bits LSB first into a shift register. After the 8th bit, write the pending_div or pending_mult register, then go to END.
- END: wait for `prog_en`=0, then go to IDLE. `prog_en` must be low for at least one cycle between commands.
- BUSY: count down to 0, then commit and return to IDLE.
  - Commit: `out_mult`←pending_mult, `out_div`←pending_div, `out_update`=1, `prog_done`←1.
- Pending registers persist across GOs. A GO with no preceding loads re-commits the current pending values.
- Invalid multiply: pending_mult==0 (M=1) at commit.
  - `out_mult`/`out_div` are not updated and `out_update` stays 0.
  - `prog_done` still returns high on schedule, so the master never hangs.
- Abort: `prog_en`=0 in SEL or DATA → return to IDLE and discard the partial command; pending registers are unchanged.
- `prog_en`=1 while in BUSY: ignored; no state change.
- Reset values: `prog_done`=1, `out_mult`=`MULT_RESET`, `out_div`=`DIV_RESET`, `out_update`=0, `err`=0, state IDLE. Pending registers take the parameter values.
- Reset mid-command or mid-BUSY: all of the above is restored; no commit.

## Timing
- All outputs are registered.
- GO sampled at cycle t:
  - `prog_done`=0 at t+1.
  - Commit, with `out_update`=1 and `prog_done`=1, at t+1+`DONE_DELAY`.
- Load command, first bit sampled at cycle t:
  - Pending register written at t+9.
  - Earliest next command bit accepted at t+11, after one cycle of `prog_en`=0.
- Back-to-back GO while BUSY does not restart the countdown.
- `out_update` is a single cycle, coincident with the new `out_mult`/`out_div` values.

## Configuration
- Macro: `DLSC_CLKGEN_PROG_RX_CHECK_EN`.
- Defined: `err` pulses for one cycle when any of these is detected:
  - abort in SEL/DATA;
  - `prog_en` still high on the first END cycle (once per command);
  - `prog_en`=1 while BUSY (once per BUSY period);
  - invalid-multiply commit (on the commit cycle).
- Undefined: `err` is tied to 0 and the check logic is removed. Functional behaviour is otherwise identical, including rejection of invalid multiply.

## Test plan
- Reset, then idle: `prog_done`=1, `out_mult`=3, `out_div`=0, `err`=0.
- LOADD 0x04, gap, LOADM 0x09, gap, GO at cycle t, `DONE_DELAY`=8:
  - `prog_done` low at t+1;
  - at t+9, `out_div`=0x04, `out_mult`=0x09, `out_update` pulse, `prog_done`=1.
- LOADM 0x00, then GO: `prog_done` returns after `DONE_DELAY`, `out_mult` keeps its previous value, no `out_update`. With the macro, `err` pulses on the commit cycle.
- LOADD aborted after 5 data bits, then GO: commit uses the previous pending_div. With the macro, one `err` pulse at the abort.
- GO, then `prog_en`=1 pulses during BUSY: completion cycle unchanged. With the macro, exactly one `err` pulse.
- `rst` asserted mid-BUSY after LOADM 0x07: no `out_update`, outputs at reset values, and a subsequent GO commits `MULT_RESET`/`DIV_RESET`.
